// File: rtl/entropy_encode_ac_level_stream.sv
`timescale 1ns/1ps
// AC level entropy encoder: adaptive Rice / Exp-Golomb codebooks in a 3-stage stall-capable pipeline.
// Optional per-code-type counters are built only when ENTROPY_AC_LEVEL_STATS_EN is defined.
module entropy_encode_ac_level_stream #(
    parameter int COEFF_W = 20,
    parameter int CODE_W  = 43,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic               in_first,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic [15:0]        stat_rice,
    output logic [15:0]        stat_exp
);
    localparam int LOG_W = $clog2(COEFF_W);

    logic               w_adv;
    logic               w_accept;
    logic [COEFF_W-1:0] w_abs;
    logic               w_zero;
    logic [COEFF_W-1:0] w_hist;
    logic [3:0]         w_idx;

    logic               r_s1Valid;
    logic               r_s1Sign;
    logic               r_s1Zero;
    logic [COEFF_W-1:0] r_s1Abs;
    logic [3:0]         r_s1Idx;
    logic [COEFF_W-1:0] r_prevAbs;

    logic [1:0]         w_sw;
    logic [1:0]         w_expK;
    logic [1:0]         w_riceK;
    logic [COEFF_W-1:0] w_val;
    logic [COEFF_W-1:0] w_thresh;
    logic               w_isRice;
    logic [COEFF_W-1:0] w_q;
    logic [COEFF_W-1:0] w_riceBody;
    logic [COEFF_W-1:0] w_expV;

    logic               r_s2Valid;
    logic               r_s2Sign;
    logic               r_s2Zero;
    logic               r_s2Rice;
    logic [COEFF_W-1:0] r_s2Body;
    logic [COEFF_W-1:0] r_s2Q;
    logic [1:0]         r_s2Sw;
    logic [1:0]         r_s2ExpK;
    logic [1:0]         r_s2RiceK;

    logic [LOG_W-1:0]   w_log2;
    logic [LEN_W-1:0]   w_lenRice;
    logic [LEN_W-1:0]   w_lenExp;
    logic [LEN_W-1:0]   w_codeLen;

    logic               r_outValid;
    logic [CODE_W-1:0]  r_outCode;
    logic [LEN_W-1:0]   r_outLen;

    assign w_adv    = out_ready | ~r_outValid;
    assign w_accept = in_valid & w_adv;
    assign in_ready = w_adv;

    assign out_valid = r_outValid;
    assign out_code  = r_outCode;
    assign out_len   = r_outLen;

    // Two's-complement magnitude; the most negative input maps to 2^(COEFF_W-1) without overflow.
    assign w_abs  = in_coeff[COEFF_W-1] ? (~in_coeff + COEFF_W'(1)) : in_coeff;
    assign w_zero = (in_coeff == '0);
    assign w_hist = in_first ? COEFF_W'(1) : r_prevAbs;
    assign w_idx  = (w_hist > COEFF_W'(9)) ? 4'd9 : w_hist[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1Sign  <= 1'b0;
            r_s1Zero  <= 1'b0;
            r_s1Abs   <= '0;
            r_s1Idx   <= '0;
            r_prevAbs <= COEFF_W'(1);
        end else begin
            if (w_adv) begin
                r_s1Valid <= in_valid;
                r_s1Sign  <= in_coeff[COEFF_W-1];
                r_s1Zero  <= w_zero;
                r_s1Abs   <= w_abs;
                r_s1Idx   <= w_idx;
            end
            if (w_accept) begin
                if (!w_zero)
                    r_prevAbs <= w_abs;
                else if (in_first)
                    r_prevAbs <= COEFF_W'(1);
            end
        end
    end

    always_comb begin
        w_sw    = 2'd0;
        w_expK  = 2'd1;
        w_riceK = 2'd0;
        case (r_s1Idx)
            4'd1: begin
                w_sw   = 2'd2;
                w_expK = 2'd2;
            end
            4'd2: w_sw = 2'd1;
            4'd3: w_sw = 2'd2;
            4'd5, 4'd6, 4'd7, 4'd8: begin
                w_expK  = 2'd2;
                w_riceK = 2'd1;
            end
            4'd9: begin
                w_expK  = 2'd3;
                w_riceK = 2'd2;
            end
            default: ;
        endcase
    end

    // Rice body is the terminating 1 followed by the remainder; the q leading zeros only add length.
    assign w_val      = r_s1Abs - COEFF_W'(1);
    assign w_thresh   = (COEFF_W'(w_sw) + COEFF_W'(1)) << w_riceK;
    assign w_isRice   = (w_val < w_thresh);
    assign w_q        = w_val >> w_riceK;
    assign w_riceBody = (COEFF_W'(1) << w_riceK) | (w_val & ((COEFF_W'(1) << w_riceK) - COEFF_W'(1)));
    assign w_expV     = w_val - w_thresh + (COEFF_W'(1) << w_expK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2Valid <= 1'b0;
            r_s2Sign  <= 1'b0;
            r_s2Zero  <= 1'b0;
            r_s2Rice  <= 1'b0;
            r_s2Body  <= '0;
            r_s2Q     <= '0;
            r_s2Sw    <= '0;
            r_s2ExpK  <= '0;
            r_s2RiceK <= '0;
        end else if (w_adv) begin
            r_s2Valid <= r_s1Valid;
            r_s2Sign  <= r_s1Sign;
            r_s2Zero  <= r_s1Zero;
            r_s2Rice  <= w_isRice;
            r_s2Body  <= w_isRice ? w_riceBody : w_expV;
            r_s2Q     <= w_q;
            r_s2Sw    <= w_sw;
            r_s2ExpK  <= w_expK;
            r_s2RiceK <= w_riceK;
        end
    end

    always_comb begin
        w_log2 = '0;
        for (int i = 0; i < COEFF_W; i++) begin
            if (r_s2Body[i])
                w_log2 = LOG_W'(i);
        end
    end

    assign w_lenRice = LEN_W'(r_s2Q) + LEN_W'(r_s2RiceK) + LEN_W'(1);
    assign w_lenExp  = (LEN_W'(w_log2) << 1) - LEN_W'(r_s2ExpK) + LEN_W'(r_s2Sw) + LEN_W'(2);
    assign w_codeLen = r_s2Rice ? w_lenRice : w_lenExp;

    // The Exp-Golomb prefix zeros sit above v, so the right-aligned value is v itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid <= 1'b0;
            r_outCode  <= '0;
            r_outLen   <= '0;
        end else if (w_adv) begin
            r_outValid <= r_s2Valid;
            if (r_s2Zero) begin
                r_outCode <= '0;
                r_outLen  <= '0;
            end else begin
                r_outCode <= CODE_W'({r_s2Body, r_s2Sign});
                r_outLen  <= w_codeLen + LEN_W'(1);
            end
        end
    end

`ifdef ENTROPY_AC_LEVEL_STATS_EN
    logic        r_outRice;
    logic [15:0] r_statRice;
    logic [15:0] r_statExp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outRice  <= 1'b0;
            r_statRice <= '0;
            r_statExp  <= '0;
        end else begin
            if (w_adv)
                r_outRice <= r_s2Rice;
            if (r_outValid && out_ready && (r_outLen != '0)) begin
                if (r_outRice && (r_statRice != 16'hFFFF))
                    r_statRice <= r_statRice + 16'd1;
                if (!r_outRice && (r_statExp != 16'hFFFF))
                    r_statExp <= r_statExp + 16'd1;
            end
        end
    end

    assign stat_rice = r_statRice;
    assign stat_exp  = r_statExp;
`else
    assign stat_rice = '0;
    assign stat_exp  = '0;
`endif

endmodule

// File: tb/tb_entropy_encode_ac_level_stream.sv
`timescale 1ns/1ps
// Directed bench for entropy_encode_ac_level_stream: codebook choice, Rice/Exp-Golomb codes, zeros, stalls, reset.
module tb_entropy_encode_ac_level_stream;
    localparam int COEFF_W = 20;
    localparam int CODE_W  = 43;
    localparam int LEN_W   = 6;

`ifdef ENTROPY_AC_LEVEL_STATS_EN
    localparam logic [15:0] EXP_RICE_AFTER = 16'd0;
    localparam logic [15:0] EXP_EXP_AFTER  = 16'd1;
`else
    localparam logic [15:0] EXP_RICE_AFTER = 16'd0;
    localparam logic [15:0] EXP_EXP_AFTER  = 16'd0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COEFF_W-1:0] in_coeff = '0;
    logic               in_first = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CODE_W-1:0]  out_code;
    logic [LEN_W-1:0]   out_len;
    logic [15:0]        stat_rice;
    logic [15:0]        stat_exp;

    int testCount = 0;
    int failCount = 0;

    logic [CODE_W-1:0] gotCode[$];
    logic [LEN_W-1:0]  gotLen[$];

    int     stimCoeff[16];
    bit     stimFirst[16];
    longint expCode[16];
    int     expLen[16];

    entropy_encode_ac_level_stream #(
        .COEFF_W(COEFF_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coeff (in_coeff),
        .in_first (in_first),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .out_len  (out_len),
        .stat_rice(stat_rice),
        .stat_exp (stat_exp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            gotCode.push_back(out_code);
            gotLen.push_back(out_len);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setStim(input int i, input int c, input bit f, input longint ec, input int el);
        stimCoeff[i] = c;
        stimFirst[i] = f;
        expCode[i]   = ec;
        expLen[i]    = el;
    endtask

    task automatic runStream(input int n);
        int guard;
        bit accepted;
        gotCode.delete();
        gotLen.delete();
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_coeff = COEFF_W'(stimCoeff[i]);
            in_first = stimFirst[i];
            guard = 0;
            accepted = 1'b0;
            while (!accepted && guard < 50) begin
                @(negedge clk);
                accepted = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_coeff = '0;
        guard = 0;
        while (gotCode.size() < n && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        testCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        testCount++;
        if (out_code !== '0) begin failCount++; $display("[TB] FAIL reset_code: got %0d want 0", out_code); end
        testCount++;
        if (out_len !== '0) begin failCount++; $display("[TB] FAIL reset_len: got %0d want 0", out_len); end
        testCount++;
        if (stat_rice !== 16'd0 || stat_exp !== 16'd0) begin
            failCount++; $display("[TB] FAIL reset_stats: got %0d/%0d want 0/0", stat_rice, stat_exp);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        testCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1;
        in_first = 1'b1;
        in_coeff = COEFF_W'(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_coeff = '0;
        testCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL latency_c1: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        testCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL latency_c2: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        testCount++;
        if (out_valid !== 1'b1 || out_code !== CODE_W'(2) || out_len !== LEN_W'(2)) begin
            failCount++;
            $display("[TB] FAIL latency_c3: got valid=%b code=%0d len=%0d want 1/2/2", out_valid, out_code, out_len);
        end
        @(posedge clk);
        #1;
        testCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL latency_bubble: got %b want 0", out_valid); end
    endtask

    task automatic test_exp_golomb();
        setStim(0, 1, 1'b1, 2, 2);
        setStim(1, -5, 1'b0, 11, 7);
        runStream(2);
        testCount++;
        if (gotCode.size() != 2) begin failCount++; $display("[TB] FAIL exp_count: got %0d want 2", gotCode.size()); end
        for (int i = 0; i < 2 && i < gotCode.size(); i++) begin
            testCount++;
            if (gotCode[i] !== CODE_W'(expCode[i]) || gotLen[i] !== LEN_W'(expLen[i])) begin
                failCount++;
                $display("[TB] FAIL exp[%0d]: got code=%0d len=%0d want code=%0d len=%0d",
                         i, gotCode[i], gotLen[i], expCode[i], expLen[i]);
            end
        end
    endtask

    task automatic test_codebook();
        setStim(0, 2, 1'b1, 2, 3);
        setStim(1, 3, 1'b0, 4, 5);
        setStim(2, 9, 1'b1, 18, 9);
        setStim(3, 1, 1'b0, 8, 4);
        setStim(4, 3, 1'b1, 2, 4);
        setStim(5, 4, 1'b0, 4, 6);
        setStim(6, 2, 1'b0, 4, 4);
        setStim(7, 6, 1'b0, 10, 7);
        setStim(8, -7, 1'b0, 17, 7);
        setStim(9, 1, 1'b0, 4, 3);
        runStream(10);
        testCount++;
        if (gotCode.size() != 10) begin failCount++; $display("[TB] FAIL book_count: got %0d want 10", gotCode.size()); end
        for (int i = 0; i < 10 && i < gotCode.size(); i++) begin
            testCount++;
            if (gotCode[i] !== CODE_W'(expCode[i]) || gotLen[i] !== LEN_W'(expLen[i])) begin
                failCount++;
                $display("[TB] FAIL book[%0d]: got code=%0d len=%0d want code=%0d len=%0d",
                         i, gotCode[i], gotLen[i], expCode[i], expLen[i]);
            end
        end
    endtask

    task automatic test_zero();
        setStim(0, 2, 1'b1, 2, 3);
        setStim(1, 0, 1'b0, 0, 0);
        setStim(2, 3, 1'b0, 4, 5);
        setStim(3, 3, 1'b1, 2, 4);
        setStim(4, 0, 1'b1, 0, 0);
        setStim(5, 4, 1'b0, 8, 7);
        runStream(6);
        testCount++;
        if (gotCode.size() != 6) begin failCount++; $display("[TB] FAIL zero_count: got %0d want 6", gotCode.size()); end
        for (int i = 0; i < 6 && i < gotCode.size(); i++) begin
            testCount++;
            if (gotCode[i] !== CODE_W'(expCode[i]) || gotLen[i] !== LEN_W'(expLen[i])) begin
                failCount++;
                $display("[TB] FAIL zero[%0d]: got code=%0d len=%0d want code=%0d len=%0d",
                         i, gotCode[i], gotLen[i], expCode[i], expLen[i]);
            end
        end
    endtask

    task automatic test_extreme();
        setStim(0, 9, 1'b1, 18, 9);
        setStim(1, -524288, 1'b0, 64'd1048583, 38);
        setStim(2, 524287, 1'b0, 64'd1048580, 38);
        runStream(3);
        testCount++;
        if (gotCode.size() != 3) begin failCount++; $display("[TB] FAIL extreme_count: got %0d want 3", gotCode.size()); end
        for (int i = 0; i < 3 && i < gotCode.size(); i++) begin
            testCount++;
            if (gotCode[i] !== CODE_W'(expCode[i]) || gotLen[i] !== LEN_W'(expLen[i])) begin
                failCount++;
                $display("[TB] FAIL extreme[%0d]: got code=%0d len=%0d want code=%0d len=%0d",
                         i, gotCode[i], gotLen[i], expCode[i], expLen[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit                bpPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int                cyc = 0;
        int                sent = 0;
        int                stallSeen = 0;
        bit                prevStall = 1'b0;
        logic [CODE_W-1:0] heldCode = '0;
        logic [LEN_W-1:0]  heldLen = '0;
        setStim(0, 1, 1'b1, 2, 2);
        setStim(1, -5, 1'b0, 11, 7);
        setStim(2, 2, 1'b0, 6, 3);
        setStim(3, 3, 1'b0, 4, 5);
        setStim(4, 0, 1'b0, 0, 0);
        setStim(5, 9, 1'b0, 14, 8);
        setStim(6, 1, 1'b0, 8, 4);
        setStim(7, -7, 1'b0, 15, 7);
        gotCode.delete();
        gotLen.delete();
        while (gotCode.size() < 8 && cyc < 200) begin
            out_ready = bpPat[cyc % 4];
            if (sent < 8) begin
                in_valid = 1'b1;
                in_coeff = COEFF_W'(stimCoeff[sent]);
                in_first = stimFirst[sent];
            end else begin
                in_valid = 1'b0;
                in_first = 1'b0;
                in_coeff = '0;
            end
            @(negedge clk);
            testCount++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failCount++;
                $display("[TB] FAIL bp_ready cyc%0d: got %b with valid=%b ready=%b", cyc, in_ready, out_valid, out_ready);
            end
            if (prevStall) begin
                stallSeen++;
                testCount++;
                if (out_valid !== 1'b1 || out_code !== heldCode || out_len !== heldLen) begin
                    failCount++;
                    $display("[TB] FAIL bp_hold cyc%0d: got %b/%0d/%0d want 1/%0d/%0d",
                             cyc, out_valid, out_code, out_len, heldCode, heldLen);
                end
            end
            prevStall = out_valid && !out_ready;
            heldCode = out_code;
            heldLen = out_len;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_coeff = '0;
        out_ready = 1'b1;
        testCount++;
        if (stallSeen == 0) begin failCount++; $display("[TB] FAIL bp_stalls: got 0 held cycles want >0"); end
        testCount++;
        if (gotCode.size() != 8) begin failCount++; $display("[TB] FAIL bp_count: got %0d want 8", gotCode.size()); end
        for (int i = 0; i < 8 && i < gotCode.size(); i++) begin
            testCount++;
            if (gotCode[i] !== CODE_W'(expCode[i]) || gotLen[i] !== LEN_W'(expLen[i])) begin
                failCount++;
                $display("[TB] FAIL bp[%0d]: got code=%0d len=%0d want code=%0d len=%0d",
                         i, gotCode[i], gotLen[i], expCode[i], expLen[i]);
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_first = 1'b1;
        in_coeff = COEFF_W'(9);
        @(posedge clk);
        #1;
        in_first = 1'b0;
        in_coeff = COEFF_W'(5);
        @(posedge clk);
        #1;
        in_coeff = COEFF_W'(-3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_coeff = '0;
        #2;
        reset_n = 1'b0;
        #1;
        testCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_async: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        testCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL midreset_edge: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        reset_n = 1'b1;
        gotCode.delete();
        gotLen.delete();
        repeat (4) @(posedge clk);
        #1;
        testCount++;
        if (gotCode.size() != 0) begin failCount++; $display("[TB] FAIL midreset_flush: got %0d items want 0", gotCode.size()); end
        setStim(0, 4, 1'b0, 8, 7);
        runStream(1);
        testCount++;
        if (gotCode.size() != 1 || gotCode[0] !== CODE_W'(8) || gotLen[0] !== LEN_W'(7)) begin
            failCount++;
            $display("[TB] FAIL midreset_hist: got n=%0d code=%0d len=%0d want 1/8/7",
                     gotCode.size(), (gotCode.size() > 0) ? gotCode[0] : '0, (gotLen.size() > 0) ? gotLen[0] : '0);
        end
        testCount++;
        if (stat_rice !== EXP_RICE_AFTER || stat_exp !== EXP_EXP_AFTER) begin
            failCount++;
            $display("[TB] FAIL midreset_stats: got %0d/%0d want %0d/%0d", stat_rice, stat_exp, EXP_RICE_AFTER, EXP_EXP_AFTER);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_exp_golomb();
        test_codebook();
        test_zero();
        test_extreme();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
